imem_loader: RTL
================

# imem_loader

Boot-time instruction memory writer: accepts a byte stream over a valid/ready handshake, packs bytes little-endian into `Width`-bit words, and drives the write port of the instruction memory that the fetch unit reads. It holds the core (`core_hold` gates the PC enable) until the program image is fully written. It sits beside the fetch stage, between an external byte source (UART/debug bridge) and the instruction memory.

## Interface
- `Width`, 32, instruction word width; multiple of 8.
- `Depth`, 256, instruction memory depth in words.
- `AddrW`, 8, word-address width; `2**AddrW >= Depth`.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse to begin a load; samples `word_count`.
- `word_count`  in  AddrW+1  number of words in the image.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  loader can accept a byte.
- `imem_we`  out  1  instruction memory write strobe.
- `imem_waddr`  out  AddrW  word address.
- `imem_wdata`  out  Width  packed word.
- `core_hold`  out  1  high forces PC enable low.
- `done`  out  1  image loaded, core released.
- `error`  out  1  load rejected or checksum failed.

## Operation
- States: IDLE, LOAD, CHECK, DONE, ERR.
- Reset: IDLE; `core_hold`=1; all other outputs 0; counters 0.
- IDLE + `start`:
  - `word_count`=0 -> DONE.
  - `word_count`>`Depth` -> ERR.
  - Otherwise latch the count -> LOAD.
- LOAD: `in_ready`=1. A byte transfers on `in_valid && in_ready`. The first byte of a word goes to bits [7:0], the next to [15:8], and so on. After `Width/8` bytes, the word is written to address = word index (starting at 0) and the index increments.
- After the last word's final byte: -> CHECK if the macro is defined, else -> DONE.
- DONE: `done`=1, `core_hold`=0, `in_ready`=0.
- ERR: `error`=1, `core_hold`=1, `in_ready`=0.
- `start` in DONE or ERR: clears `done`/`error`, sets `core_hold`=1, and re-evaluates `word_count` as in IDLE.
- `start` in LOAD or CHECK is ignored.
- Bytes arriving while `in_ready`=0 are not consumed.
- `rst_n` low mid-load: immediate return to reset values. Partially written memory contents are undefined.

## Timing
- `imem_we` is a one-cycle pulse in the cycle after the word's final byte is accepted. `imem_waddr` and `imem_wdata` are valid in that same cycle.
- Byte acceptance continues during the write cycle. Throughput is one byte per clock, with no bubble between words.
- Without the macro: `done` rises in the cycle of the final `imem_we` + 1.
- With the macro: `done` or `error` rises in the cycle after the checksum byte is accepted.
- `word_count`=0 or `word_count`>`Depth`: `done`/`error` rises the cycle after `start`, and no write occurs.
- All outputs are registered.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined: after the last data byte, CHECK asserts `in_ready` and accepts one more byte.
  - The expected value is the 8-bit sum, mod 256, of all data bytes.
  - Match -> DONE; mismatch -> ERR.
  - For `word_count`=0, CHECK is skipped.
- Undefined: CHECK is unreachable, no checksum byte is consumed, and `error` arises only from an oversize `word_count`.

## Structure
- Package `imem_loader_pkg`:
  - state enum (IDLE, LOAD, CHECK, DONE, ERR).
  - `BYTE_W`=8.
  - function for bytes per word (`Width/8`).
- Sub-module `byte_packer`:
  - byte lane counter and shift/insert register.
  - outputs `word_valid` pulse and packed word.
- Top level: FSM, word index counter, checksum accumulator, and output registers.

## Test plan
- Reset: assert `rst_n`=0 -> `core_hold`=1, `in_ready`=0, `imem_we`=0, `done`=0, `error`=0.
- Normal load: `word_count`=2, bytes 13 00 00 00 93 00 10 00 sent back-to-back -> writes 0x00000013 @0 and 0x00100093 @1, one clock per byte. `done`=1 and `core_hold`=0 one cycle after the second write.
- Oversize and zero counts:
  - `word_count`=Depth+1 -> `error`=1 next cycle, no `imem_we`.
  - `word_count`=0 -> `done`=1 next cycle.
- Backpressure gaps: `in_valid` toggling 1/0 each cycle with the same bytes -> identical writes. A `start` pulse mid-LOAD has no effect.
- Reset mid-load: `rst_n` pulsed after 5 bytes -> IDLE. A fresh `start` loads cleanly from address 0.
- With `IMEM_LOADER_CHECKSUM_EN`: image above plus byte 0xB6 -> `done`=1. Same image plus byte 0xB7 -> `error`=1, `core_hold` stays 1.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
// Shared types and constants for the boot-time instruction memory loader.
//   state_t        : loader FSM states
//   BYTE_W         : width of one stream byte
//   bytes_per_word : number of stream bytes packed into one memory word
package imem_loader_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  function automatic int bytes_per_word(input int width);
    return width / BYTE_W;
  endfunction

endpackage

// File: rtl/byte_packer.sv
// byte_packer
// Collects stream bytes little-endian into a Width-bit word and emits a
// one-cycle registered pulse with the completed word.
// Ports:
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_clear          : restart packing at lane 0 (new image)
//   i_push, i_byte   : byte accepted this cycle and its value
//   o_lane_last      : the next pushed byte completes a word
//   o_word_valid     : pulse in the cycle after a word completes
//   o_word           : completed word, valid with o_word_valid
module byte_packer
  import imem_loader_pkg::*;
#(
  parameter int Width = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic [7:0]       i_byte,
  output logic             o_lane_last,
  output logic             o_word_valid,
  output logic [Width-1:0] o_word
);

  localparam int BPW   = bytes_per_word(Width);
  localparam int LaneW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [LaneW-1:0] LaneLast = LaneW'(BPW - 1);
  localparam logic [LaneW-1:0] LaneOne  = LaneW'(1);

  logic [LaneW-1:0] r_lane;
  logic [Width-1:0] r_shift;
  logic [Width-1:0] w_next;
  logic             r_word_valid;
  logic [Width-1:0] r_word;

  // Insert the incoming byte into its lane; the finished word is taken from
  // this so the last byte does not need an extra cycle.
  always_comb begin
    w_next = r_shift;
    for (int k = 0; k < BPW; k++) begin
      if (r_lane == LaneW'(k)) w_next[k*BYTE_W +: BYTE_W] = i_byte;
    end
  end

  assign o_lane_last  = (r_lane == LaneLast);
  assign o_word_valid = r_word_valid;
  assign o_word       = r_word;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lane       <= '0;
      r_shift      <= '0;
      r_word_valid <= 1'b0;
      r_word       <= '0;
    end else begin
      r_word_valid <= 1'b0;
      if (i_clear) begin
        r_lane <= '0;
      end else if (i_push) begin
        r_shift <= w_next;
        if (o_lane_last) begin
          r_lane       <= '0;
          r_word_valid <= 1'b1;
          r_word       <= w_next;
        end else begin
          r_lane <= r_lane + LaneOne;
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader
// Boot-time instruction memory writer. Accepts a byte stream over
// valid/ready, packs it little-endian into Width-bit words and writes them
// to consecutive instruction memory addresses from 0, holding the core
// until the image is complete.
// Ports:
//   i_clk, i_rst_n        : clock, asynchronous active-low reset
//   i_start, i_word_count : begin a load of i_word_count words
//   i_in_data/valid, o_in_ready : byte stream handshake
//   o_imem_we/waddr/wdata : instruction memory write port
//   o_core_hold           : forces the PC enable low while high
//   o_done, o_error       : image loaded / load rejected
// Configuration macro: IMEM_LOADER_CHECKSUM_EN -- when defined, one extra
// byte holding the mod-256 sum of the data bytes is read and verified.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int Width = 32,
  parameter int Depth = 256,
  parameter int AddrW = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [AddrW:0]   i_word_count,
  input  logic [7:0]       i_in_data,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  output logic             o_imem_we,
  output logic [AddrW-1:0] o_imem_waddr,
  output logic [Width-1:0] o_imem_wdata,
  output logic             o_core_hold,
  output logic             o_done,
  output logic             o_error
);

  localparam logic [AddrW:0] DepthLim = (AddrW + 1)'(Depth);
  localparam logic [AddrW:0] IdxOne   = (AddrW + 1)'(1);

  state_t           r_state;
  logic             r_in_ready;
  logic             r_core_hold;
  logic             r_done;
  logic             r_error;
  logic [AddrW:0]   r_count;
  logic [AddrW:0]   r_widx;
  logic [AddrW-1:0] r_waddr;
  logic             r_drain;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]       r_sum;
`endif

  logic             w_accept;
  logic             w_push;
  logic             w_begin;
  logic             w_lane_last;
  logic             w_last_word;
  logic             w_word_valid;
  logic [Width-1:0] w_word;

  assign w_accept    = i_in_valid && r_in_ready;
  assign w_push      = w_accept && (r_state == S_LOAD);
  assign w_begin     = i_start && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                   (r_state == S_ERR));
  assign w_last_word = ((r_widx + IdxOne) == r_count);

  byte_packer #(
    .Width(Width)
  ) u_packer (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_clear     (w_begin),
    .i_push      (w_push),
    .i_byte      (i_in_data),
    .o_lane_last (w_lane_last),
    .o_word_valid(w_word_valid),
    .o_word      (w_word)
  );

  // The memory strobe and data come straight from the packer's registers;
  // the address is registered here at the same edge the word completes.
  assign o_imem_we    = w_word_valid;
  assign o_imem_wdata = w_word;
  assign o_imem_waddr = r_waddr;
  assign o_in_ready   = r_in_ready;
  assign o_core_hold  = r_core_hold;
  assign o_done       = r_done;
  assign o_error      = r_error;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_core_hold <= 1'b1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_count     <= '0;
      r_widx      <= '0;
      r_waddr     <= '0;
      r_drain     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_sum       <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (i_start) begin
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_core_hold <= 1'b1;
            r_widx      <= '0;
            r_drain     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum       <= '0;
`endif
            if (i_word_count == '0) begin
              r_state     <= S_DONE;
              r_done      <= 1'b1;
              r_core_hold <= 1'b0;
            end else if (i_word_count > DepthLim) begin
              r_state <= S_ERR;
              r_error <= 1'b1;
            end else begin
              r_count    <= i_word_count;
              r_state    <= S_LOAD;
              r_in_ready <= 1'b1;
            end
          end
        end

        S_LOAD: begin
          // r_drain waits out the final write cycle so done follows it.
          if (r_drain) begin
            r_drain     <= 1'b0;
            r_state     <= S_DONE;
            r_done      <= 1'b1;
            r_core_hold <= 1'b0;
          end else if (w_accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum <= r_sum + i_in_data;
`endif
            if (w_lane_last) begin
              r_waddr <= r_widx[AddrW-1:0];
              r_widx  <= r_widx + IdxOne;
              if (w_last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                r_state <= S_CHECK;
`else
                r_in_ready <= 1'b0;
                r_drain    <= 1'b1;
`endif
              end
            end
          end
        end

        S_CHECK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          if (w_accept) begin
            r_in_ready <= 1'b0;
            if (i_in_data == r_sum) begin
              r_state     <= S_DONE;
              r_done      <= 1'b1;
              r_core_hold <= 1'b0;
            end else begin
              r_state <= S_ERR;
              r_error <= 1'b1;
            end
          end
`else
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
`endif
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
